// File: rtl/clk_gen_div_if.sv
// ----------------------------------------------------------------------------
// clk_gen_div_if
// Control/status bundle for the programmable clock divider.
//   start, stop           : run control (master -> slave)
//   div_half, num_cycles  : run settings, latched by the slave on start
//   clk_out               : divided 50%-duty clock (slave -> master)
//   rise, fall, done      : one-cycle strobes
//   busy                  : generation in progress
//   cycle_cnt             : completed output periods since the last start
// ----------------------------------------------------------------------------
interface clk_gen_div_if #(
    parameter int CNT_W = 16
);
    logic             start;
    logic             stop;
    logic [CNT_W-1:0] div_half;
    logic [CNT_W-1:0] num_cycles;
    logic             clk_out;
    logic             rise;
    logic             fall;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cycle_cnt;

    modport master (
        output start, stop, div_half, num_cycles,
        input  clk_out, rise, fall, busy, done, cycle_cnt
    );

    modport slave (
        input  start, stop, div_half, num_cycles,
        output clk_out, rise, fall, busy, done, cycle_cnt
    );
endinterface

// File: rtl/clk_gen_div.sv
// ----------------------------------------------------------------------------
// clk_gen_div
// Derives a divided 50%-duty clock from clk. A run is started with start,
// uses a half-period of max(div_half,1) clk cycles and ends either after
// num_cycles output periods (0 = free-run) or gracefully on stop. Edge
// strobes (rise/fall), a done pulse and a period counter are provided.
// Ports:
//   clk   : system clock, all logic on posedge
//   rst_n : asynchronous active-low reset
//   bus   : clk_gen_div_if slave modport (control in, clock/status out)
// ----------------------------------------------------------------------------
module clk_gen_div #(
    parameter int CNT_W = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    clk_gen_div_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO = '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] half_cnt_q, half_cnt_d;
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] dh_q, dh_d;
    logic [CNT_W-1:0] nc_q, nc_d;
    logic             clk_out_q, clk_out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic             toggle;
    logic             finish;
    logic             term_hit;

    // Terminal count compares one bit wider so the +1 never wraps before
    // it is matched against a non-zero limit.
    assign term_hit = (nc_q != ZERO) &&
                      (({1'b0, cycle_cnt_q} + {1'b0, ONE}) == {1'b0, nc_q});
    assign toggle   = (half_cnt_q == (dh_q - ONE));

    always_comb begin
        state_d     = state_q;
        half_cnt_d  = half_cnt_q;
        cycle_cnt_d = cycle_cnt_q;
        dh_d        = dh_q;
        nc_d        = nc_q;
        clk_out_d   = clk_out_q;
        busy_d      = busy_q;
        rise_d      = 1'b0;
        fall_d      = 1'b0;
        done_d      = 1'b0;
        finish      = 1'b0;

        case (state_q)
            IDLE: begin
                // stop is not looked at here, so start+stop simply starts
                if (bus.start) begin
                    state_d     = RUN;
                    dh_d        = (bus.div_half == ZERO) ? ONE : bus.div_half;
                    nc_d        = bus.num_cycles;
                    half_cnt_d  = ZERO;
                    cycle_cnt_d = ZERO;
                    clk_out_d   = 1'b0;
                    busy_d      = 1'b1;
                end
            end

            RUN, DRAIN: begin
                if (toggle) begin
                    half_cnt_d = ZERO;
                    clk_out_d  = ~clk_out_q;
                    if (!clk_out_q) begin
                        rise_d = 1'b1;
                    end else begin
                        fall_d      = 1'b1;
                        cycle_cnt_d = cycle_cnt_q + ONE;
                        // A drain always ends on its fall; terminal count
                        // folds into the same single done pulse.
                        if (term_hit || (state_q == DRAIN)) begin
                            finish = 1'b1;
                        end
                    end
                end else begin
                    half_cnt_d = half_cnt_q + ONE;
                end

                // stop is judged against the post-toggle clock level: low
                // means nothing left to finish, high means let it complete.
                if ((state_q == RUN) && !finish && bus.stop) begin
                    if (!clk_out_d) begin
                        finish = 1'b1;
                    end else begin
                        state_d = DRAIN;
                    end
                end

                if (finish) begin
                    state_d    = IDLE;
                    half_cnt_d = ZERO;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end
            end

            default: begin
                state_d   = IDLE;
                clk_out_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            half_cnt_q  <= '0;
            cycle_cnt_q <= '0;
            dh_q        <= '0;
            nc_q        <= '0;
            clk_out_q   <= 1'b0;
            rise_q      <= 1'b0;
            fall_q      <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            half_cnt_q  <= half_cnt_d;
            cycle_cnt_q <= cycle_cnt_d;
            dh_q        <= dh_d;
            nc_q        <= nc_d;
            clk_out_q   <= clk_out_d;
            rise_q      <= rise_d;
            fall_q      <= fall_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.clk_out   = clk_out_q;
    assign bus.rise      = rise_q;
    assign bus.fall      = fall_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.cycle_cnt = cycle_cnt_q;

endmodule

// File: tb/tb_clk_gen_div.sv
// ----------------------------------------------------------------------------
// tb_clk_gen_div
// Directed bench for clk_gen_div. Each scenario queues the strobe events it
// expects (edge index plus full output snapshot); a monitor pops and
// compares whenever rise, fall or done is seen.
// ----------------------------------------------------------------------------
module tb_clk_gen_div;

    localparam int CNT_W = 16;

    typedef struct {
        int               cyc;
        logic             r;
        logic             f;
        logic             d;
        logic             co;
        logic             b;
        logic [CNT_W-1:0] cnt;
    } ev_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   errors;
    ev_t  exp_q[$];

    clk_gen_div_if #(.CNT_W(CNT_W)) bus ();

    clk_gen_div #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic push(input int c, input logic r, input logic f, input logic d,
                        input logic co, input logic b, input logic [CNT_W-1:0] cnt);
        ev_t e;
        e.cyc = c; e.r = r; e.f = f; e.d = d; e.co = co; e.b = b; e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // Advance to the negedge following posedge number c.
    task automatic wait_neg(input int c);
        do @(negedge clk); while (cyc < c);
    endtask

    task automatic start_run(input logic [CNT_W-1:0] dh, input logic [CNT_W-1:0] nc,
                             input logic stp, output int s);
        @(negedge clk);
        bus.div_half   = dh;
        bus.num_cycles = nc;
        bus.start      = 1'b1;
        bus.stop       = stp;
        s = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.stop  = 1'b0;
    endtask

    task automatic stop_at(input int c);
        wait_neg(c - 1);
        bus.stop = 1'b1;
        wait_neg(c);
        bus.stop = 1'b0;
    endtask

    task automatic drain_check(input string name);
        check({name, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Monitor: every strobe must match the next queued event.
    always @(negedge clk) begin
        if (rst_n && (bus.rise || bus.fall || bus.done)) begin
            logic [20:0] act;
            logic [20:0] expv;
            ev_t e;
            act = {bus.rise, bus.fall, bus.done, bus.clk_out, bus.busy, bus.cycle_cnt};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe at cycle %0d: got r/f/d/co/b/cnt=%0h expected none",
                         cyc, act);
            end else begin
                e = exp_q.pop_front();
                expv = {e.r, e.f, e.d, e.co, e.b, e.cnt};
                if ((e.cyc != cyc) || (act !== expv)) begin
                    errors++;
                    $display("FAIL strobe_event: got cycle %0d r/f/d/co/b/cnt=%0h expected cycle %0d %0h",
                             cyc, act, e.cyc, expv);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        checks = 0;
        errors = 0;
        cyc    = 0;
        bus.start      = 1'b0;
        bus.stop       = 1'b0;
        bus.div_half   = '0;
        bus.num_cycles = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset_state",
              {bus.clk_out, bus.rise, bus.fall, bus.busy, bus.done, bus.cycle_cnt}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Bounded run: dh=2, nc=3
        start_run(16'd2, 16'd3, 1'b0, s);
        push(s + 2,  1, 0, 0, 1, 1, 0);
        push(s + 4,  0, 1, 0, 0, 1, 1);
        push(s + 6,  1, 0, 0, 1, 1, 1);
        push(s + 8,  0, 1, 0, 0, 1, 2);
        push(s + 10, 1, 0, 0, 1, 1, 2);
        push(s + 12, 0, 1, 1, 0, 0, 3);
        wait_neg(s + 13);
        check("bounded_after_done", {bus.done, bus.busy, bus.clk_out, bus.cycle_cnt}, 32'h3);
        wait_neg(s + 15);
        drain_check("bounded");

        // Zero divider: dh=0 treated as 1, nc=2
        start_run(16'd0, 16'd2, 1'b0, s);
        push(s + 1, 1, 0, 0, 1, 1, 0);
        push(s + 2, 0, 1, 0, 0, 1, 1);
        push(s + 3, 1, 0, 0, 1, 1, 1);
        push(s + 4, 0, 1, 1, 0, 0, 2);
        wait_neg(s + 6);
        drain_check("zero_div");

        // Graceful stop while high: dh=4 free-run, stop at E5
        start_run(16'd4, 16'd0, 1'b0, s);
        push(s + 4, 1, 0, 0, 1, 1, 0);
        push(s + 8, 0, 1, 1, 0, 0, 1);
        stop_at(s + 5);
        wait_neg(s + 7);
        check("drain_high_busy", {bus.clk_out, bus.busy}, 2'b11);
        wait_neg(s + 10);
        drain_check("graceful");

        // Immediate stop while low: dh=4 free-run, stop at E9
        start_run(16'd4, 16'd0, 1'b0, s);
        push(s + 4, 1, 0, 0, 1, 1, 0);
        push(s + 8, 0, 1, 0, 0, 1, 1);
        push(s + 9, 0, 0, 1, 0, 0, 1);
        stop_at(s + 9);
        wait_neg(s + 12);
        check("imm_stop_idle", {bus.clk_out, bus.busy, bus.cycle_cnt}, 32'h1);
        drain_check("immediate");

        // Priority: start+stop in IDLE starts; start at E3 with new div ignored
        start_run(16'd3, 16'd2, 1'b1, s);
        push(s + 3,  1, 0, 0, 1, 1, 0);
        push(s + 6,  0, 1, 0, 0, 1, 1);
        push(s + 9,  1, 0, 0, 1, 1, 1);
        push(s + 12, 0, 1, 1, 0, 0, 2);
        wait_neg(s + 2);
        bus.start    = 1'b1;
        bus.div_half = 16'd1;
        wait_neg(s + 3);
        bus.start = 1'b0;
        wait_neg(s + 14);
        drain_check("priority");

        // Async reset mid-run while clk_out is high
        start_run(16'd2, 16'd0, 1'b0, s);
        push(s + 2, 1, 0, 0, 1, 1, 0);
        push(s + 4, 0, 1, 0, 0, 1, 1);
        push(s + 6, 1, 0, 0, 1, 1, 1);
        wait_neg(s + 7);
        check("pre_reset_high", {bus.clk_out, bus.busy, bus.cycle_cnt}, 32'h30001);
        rst_n = 1'b0;
        #1;
        check("async_reset_now",
              {bus.clk_out, bus.busy, bus.done, bus.rise, bus.fall, bus.cycle_cnt}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("post_reset_quiet", {bus.clk_out, bus.busy, bus.done, bus.cycle_cnt}, 0);
        drain_check("reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_gen_div.md
Name: clk_gen_div

Overview:
- Programmable clock generator that derives a divided, 50%-duty clock from the single system clock. It produces edge-strobe pulses and a bounded cycle count.
- Sits directly downstream of the testbench clock source and upstream of any block needing a slower, countable clock. Example: 100 MHz in, 25 MHz out with DIV_HALF=2.
- Replaces hand-written "#delay clk=~clk" loops plus "#N $finish" timeouts with a start/stop/done-controlled, synthesizable block.

Parameters:
- CNT_W, 16, width of the half-period setting, the cycle-count limit and the cycle counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin generation; sampled only in IDLE.
- stop  in  1  request graceful stop; sampled only in RUN.
- div_half  in  CNT_W  half-period in clk cycles; latched on start; 0 is treated as 1.
- num_cycles  in  CNT_W  output periods to generate; latched on start; 0 means free-run until stop.
- clk_out  out  1  divided clock, registered.
- rise  out  1  one-cycle strobe, high in the same cycle clk_out first reads 1.
- fall  out  1  one-cycle strobe, high in the same cycle clk_out first reads 0 after a high phase.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when generation ends.
- cycle_cnt  out  CNT_W  completed output periods (falling edges) since the last start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. clk_out, rise, fall, busy, done, cycle_cnt, half_cnt and the latched registers all 0. Deassertion is sampled synchronously at the next posedge.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start=1 → RUN at that edge. Latch dh=max(div_half,1) and nc=num_cycles. Clear half_cnt and cycle_cnt. clk_out=0, busy=1.
  - stop is ignored in IDLE. start with stop in the same cycle → start wins.
- RUN, each edge:
  - If half_cnt==dh-1: toggle clk_out and clear half_cnt. Otherwise half_cnt+1.
  - Toggle 0→1: rise=1.
  - Toggle 1→0: fall=1 and cycle_cnt+1.
  - Latency: with start sampled at edge E0, clk_out rises at E0+dh and falls at E0+2·dh. Period 2·dh, duty exactly 50%.
  - Terminal count: a falling toggle with nc≠0 and cycle_cnt+1==nc → IDLE at that same edge; done=1, busy=0.
  - stop=1 with clk_out=0 and no toggle this edge → IDLE immediately; done=1, busy=0, cycle_cnt unchanged.
  - stop=1 with clk_out=1 → DRAIN. Counting continues and the high phase completes at full length.
  - stop=1 on an edge where clk_out toggles: the toggle happens first, then the rule above is applied to the new clk_out value.
  - start while busy is ignored. Latched dh/nc never change mid-run.
- DRAIN:
  - Same counting as RUN. The next falling toggle increments cycle_cnt, sets fall=1 and done=1, and → IDLE.
  - Terminal count reached on that fall → identical outcome, with a single done pulse.
  - stop and start are ignored.
- Strobes rise, fall and done are high for exactly one cycle, then 0.
- cycle_cnt holds its final value in IDLE until the next start.
- cycle_cnt wraps modulo 2^CNT_W in free-run with no flag. The nc comparison uses the pre-wrap +1 value, so nc≠0 always terminates.
- clk_out is always 0 in IDLE. A glitch-free high phase of exactly dh cycles is guaranteed except on async reset.
- Async reset mid-run: all outputs 0 immediately, no done pulse.

Test Plan:
- Reset: rst_n=0 mid-run while clk_out=1 → clk_out, busy and cycle_cnt read 0 before the next posedge. After release, no activity until start.
- Bounded run, start at E0 with div_half=2 and num_cycles=3:
  - clk_out rises at E2/E6/E10 and falls at E4/E8/E12.
  - rise and fall pulse at those edges.
  - At E12: done=1, busy=0, cycle_cnt=3. done=0 at E13.
- Zero divider, div_half=0 and num_cycles=2 → period 2 clk, clk_out toggles every edge, done at E4, cycle_cnt=2.
- Graceful stop, div_half=4 and num_cycles=0, stop pulsed at E5 while clk_out=1 → state DRAIN; fall and done at E8; cycle_cnt=1; clk_out high phase exactly 4 cycles.
- Immediate stop, div_half=4, stop pulsed at E9 while clk_out=0 (no toggle) → done at E9, cycle_cnt=1, clk_out stays 0.
- Priority, start+stop together in IDLE → run starts. A second start at E3 with different div_half → ignored, and the period is unchanged.
